// File: rtl/regex_pkg.sv
// ---------------------------------------------------------------------------
// regex_pkg
//
// Shared definitions for the regex engine leaf elements.
//   - state_t and the IDLE/SAMPLE/EVAL/DONE encodings for the matcher FSM
//   - ASCII constants used by case folding
//   - to_lower(): maps 'A'..'Z' onto 'a'..'z' and leaves every other code alone
// ---------------------------------------------------------------------------
package regex_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SAMPLE = 2'd1;
    localparam state_t EVAL   = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_Z_UP  = 8'h5A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    // Only the upper-case letters move; '[' (8'h5B) and '@' (8'h40) stay put.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if ((c >= CH_A_UP) && (c <= CH_Z_UP)) begin
            return c | CASE_BIT;
        end
        return c;
    endfunction

endpackage

// File: rtl/char_class_cmp.sv
// ---------------------------------------------------------------------------
// char_class_cmp
//
// Purely combinational character-class test: is c inside LO..HI (inclusive,
// unsigned), optionally after case folding, optionally negated.
// LO > HI is an empty class, so match is 0 (1 when negated).
//
// Ports
//   c      in   WIDTH  character under test
//   match  out  1      class membership result (after NEGATE)
// ---------------------------------------------------------------------------
module char_class_cmp
    import regex_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] LO        = 8'h61,
    parameter logic [WIDTH-1:0] HI        = 8'h61,
    parameter bit               NEGATE    = 1'b0,
    parameter bit               CASE_FOLD = 1'b0
) (
    input  logic [WIDTH-1:0] c,
    output logic             match
);

    logic [WIDTH-1:0] c_f;
    logic [WIDTH-1:0] lo_f;
    logic [WIDTH-1:0] hi_f;
    logic             in_range;

    generate
        if (WIDTH == 8) begin : g_w8
            assign c_f  = CASE_FOLD ? to_lower(c)  : c;
            assign lo_f = CASE_FOLD ? to_lower(LO) : LO;
            assign hi_f = CASE_FOLD ? to_lower(HI) : HI;
        end else begin : g_wide
            // Wider alphabets: fold the same ASCII letter range, zero-extended.
            localparam logic [WIDTH-1:0] AUp = WIDTH'(CH_A_UP);
            localparam logic [WIDTH-1:0] ZUp = WIDTH'(CH_Z_UP);
            localparam logic [WIDTH-1:0] CBit = WIDTH'(CASE_BIT);

            function automatic logic [WIDTH-1:0] fold_w(input logic [WIDTH-1:0] v);
                if ((v >= AUp) && (v <= ZUp)) begin
                    return v | CBit;
                end
                return v;
            endfunction

            assign c_f  = CASE_FOLD ? fold_w(c)  : c;
            assign lo_f = CASE_FOLD ? fold_w(LO) : LO;
            assign hi_f = CASE_FOLD ? fold_w(HI) : HI;
        end
    endgenerate

    assign in_range = (c_f >= lo_f) && (c_f <= hi_f);
    assign match    = NEGATE ? ~in_range : in_range;

endmodule

// File: rtl/char_match.sv
// ---------------------------------------------------------------------------
// char_match
//
// Single-character matcher, leaf element of the regex engine. After reset is
// released the FSM walks IDLE -> SAMPLE -> EVAL -> DONE: x is captured in
// SAMPLE, the class result is registered in EVAL, and DONE holds rdy=1 with
// y frozen until the next reset. rdy and y load on the same edge, so y never
// changes while rdy is high.
//
// Ports
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous active-low reset
//   rdy    out  1      result valid, held until the next reset
//   x      in   WIDTH  character under test, stable from reset release to rdy
//   y      out  1      match result, meaningful while rdy=1
// ---------------------------------------------------------------------------
module char_match
    import regex_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] LO        = 8'h61,
    parameter logic [WIDTH-1:0] HI        = 8'h61,
    parameter bit               NEGATE    = 1'b0,
    parameter bit               CASE_FOLD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             rdy,
    input  logic [WIDTH-1:0] x,
    output logic             y
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             y_q, y_d;
    logic             rdy_q, rdy_d;
    logic             match;

    char_class_cmp #(
        .WIDTH     (WIDTH),
        .LO        (LO),
        .HI        (HI),
        .NEGATE    (NEGATE),
        .CASE_FOLD (CASE_FOLD)
    ) u_cmp (
        .c     (x_q),
        .match (match)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                x_d     = x;
                state_d = EVAL;
            end
            EVAL: begin
                y_d     = match;
                rdy_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Terminal: only reset starts a new evaluation.
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rdy = rdy_q;
    assign y   = y_q;

endmodule

// File: tb/tb_char_match.sv
// ---------------------------------------------------------------------------
// tb_char_match
//
// Directed bench. Six matcher instances with different classes share clock and
// reset; each run drives one character per instance and checks rdy timing and
// the hand-computed y values.
//   u_def : default 'a' literal
//   u_dig : '0'..'9'
//   u_neg : [^a]
//   u_fold: 'a' with case folding
//   u_emp : empty class (LO > HI)
//   u_eng : negated empty class
// ---------------------------------------------------------------------------
module tb_char_match;

    logic       clk;
    logic       reset;
    logic [7:0] x_def, x_dig, x_neg, x_fold, x_emp, x_eng;
    logic       rdy_def, rdy_dig, rdy_neg, rdy_fold, rdy_emp, rdy_eng;
    logic       y_def, y_dig, y_neg, y_fold, y_emp, y_eng;

    int n_assert;
    int n_fail;

    char_match u_def (
        .clk (clk), .reset (reset), .rdy (rdy_def), .x (x_def), .y (y_def)
    );

    char_match #(.LO (8'h30), .HI (8'h39)) u_dig (
        .clk (clk), .reset (reset), .rdy (rdy_dig), .x (x_dig), .y (y_dig)
    );

    char_match #(.LO (8'h61), .HI (8'h61), .NEGATE (1'b1)) u_neg (
        .clk (clk), .reset (reset), .rdy (rdy_neg), .x (x_neg), .y (y_neg)
    );

    char_match #(.LO (8'h61), .HI (8'h61), .CASE_FOLD (1'b1)) u_fold (
        .clk (clk), .reset (reset), .rdy (rdy_fold), .x (x_fold), .y (y_fold)
    );

    char_match #(.LO (8'h62), .HI (8'h61)) u_emp (
        .clk (clk), .reset (reset), .rdy (rdy_emp), .x (x_emp), .y (y_emp)
    );

    char_match #(.LO (8'h62), .HI (8'h61), .NEGATE (1'b1)) u_eng (
        .clk (clk), .reset (reset), .rdy (rdy_eng), .x (x_eng), .y (y_eng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] all_rdy();
        return {rdy_def, rdy_dig, rdy_neg, rdy_fold, rdy_emp, rdy_eng};
    endfunction

    // Directed vectors: characters per instance and expected y per instance.
    typedef struct {
        logic [7:0] xd, xg, xn, xf, xe, xq;
        logic       yd, yg, yn, yf, ye, yq;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        reset = 1'b0;
        x_def = v.xd; x_dig = v.xg; x_neg = v.xn;
        x_fold = v.xf; x_emp = v.xe; x_eng = v.xq;
        #2;
        // Previous run left everything in DONE; reset clears without an edge.
        check_eq($sformatf("v%0d async_rdy", idx), 32'(all_rdy()), 32'h0);
        check_eq($sformatf("v%0d async_y", idx),
                 32'({y_def, y_dig, y_neg, y_fold, y_emp, y_eng}), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("v%0d rdy_e%0d", idx, e), 32'(all_rdy()),
                     (e == 3) ? 32'h3f : 32'h0);
        end
        check_eq($sformatf("v%0d y_def", idx),  32'(y_def),  32'(v.yd));
        check_eq($sformatf("v%0d y_dig", idx),  32'(y_dig),  32'(v.yg));
        check_eq($sformatf("v%0d y_neg", idx),  32'(y_neg),  32'(v.yn));
        check_eq($sformatf("v%0d y_fold", idx), 32'(y_fold), 32'(v.yf));
        check_eq($sformatf("v%0d y_emp", idx),  32'(y_emp),  32'(v.ye));
        check_eq($sformatf("v%0d y_eng", idx),  32'(y_eng),  32'(v.yq));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        x_def = 8'h00; x_dig = 8'h00; x_neg = 8'h00;
        x_fold = 8'h00; x_emp = 8'h00; x_eng = 8'h00;

        //           xd     xg     xn     xf     xe     xq     yd    yg    yn    yf    ye    yq
        vecs[0] = '{8'h61, 8'h2F, 8'h61, 8'h41, 8'h61, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h62, 8'h30, 8'h7A, 8'h5B, 8'h62, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h41, 8'h39, 8'h60, 8'h61, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h61, 8'h3A, 8'h61, 8'h7B, 8'hFF, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h5A, 8'h61, 8'h61, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        #12;
        check_eq("reset_rdy", 32'(all_rdy()), 32'h0);
        check_eq("reset_y", 32'({y_def, y_dig, y_neg, y_fold, y_emp, y_eng}), 32'h0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        // Reset pulses in SAMPLE and in EVAL, then a clean release.
        @(negedge clk);
        reset = 1'b0;
        x_def = 8'h61;
        x_dig = 8'h35;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_sample_rdy", 32'(rdy_def), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_eval_rdy", 32'(rdy_def), 32'h0);
        check_eq("mid_eval_y", 32'(y_def), 32'h0);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("mid_rdy_e%0d", e), 32'(rdy_def), (e == 3) ? 32'h1 : 32'h0);
        end
        check_eq("mid_y_def", 32'(y_def), 32'h1);
        check_eq("mid_y_dig", 32'(y_dig), 32'h1);

        // x changes in DONE must not disturb y.
        x_def = 8'h62;
        x_dig = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_hold_y_def", 32'(y_def), 32'h1);
        check_eq("done_hold_y_dig", 32'(y_dig), 32'h1);
        check_eq("done_hold_rdy", 32'(rdy_def), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
